// File: rtl/prog_loader.sv
// Byte-stream loader for instruction and data memories.
// Holds the CPU in stall until a complete load session finishes.
module prog_loader #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;

  state_e state_q, state_d;

  logic              tgt_q, tgt_d;
  logic [7:0]        cnth_q, cnth_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       asm_q, asm_d;
  logic              hold_q, hold_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;

  logic        acc;
  logic [15:0] cnt_n;
  logic [31:0] word_n;

  assign cnt_n  = {cnth_q, in_data};
  assign word_n = {asm_q[23:0], in_data};

  // Ready only while a byte-consuming state is active and out of reset
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      unique case (state_q)
        S_IDLE, S_CNT_HI,
        S_CNT_LO, S_DATA: in_ready = 1'b1;
        default:          in_ready = 1'b0;
      endcase
    end
  end

  assign acc = in_valid && in_ready;

  // Session sequencing and word assembly
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnth_d     = cnth_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    bidx_d     = bidx_q;
    asm_d      = asm_q;
    hold_d     = hold_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    dm_we_d    = 1'b0;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          hold_d = 1'b1;
          if (in_data[6:0] != 7'd0) begin
            state_d = S_ERROR;
          end else begin
            tgt_d   = in_data[7];
            state_d = S_CNT_HI;
          end
        end
      end
      S_CNT_HI: begin
        if (acc) begin
          cnth_d  = in_data;
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (acc) begin
          if (cnt_n == 16'd0) begin
            hold_d  = 1'b0;
            state_d = S_DONE;
          end else if (cnt_n > 16'(DEPTH)) begin
            state_d = S_ERROR;
          end else begin
            cnt_d   = cnt_n;
            idx_d   = 16'd0;
            bidx_d  = 2'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          asm_d  = word_n;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d = S_WRITE;
            if (tgt_q) begin
              dm_we_d    = 1'b1;
              dm_addr_d  = idx_q[ADDR_W-1:0];
              dm_wdata_d = word_n;
            end else begin
              im_we_d    = 1'b1;
              im_addr_d  = idx_q[ADDR_W-1:0];
              im_wdata_d = word_n;
            end
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 16'd1;
        if (idx_q + 16'd1 == cnt_q) begin
          hold_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered write-port outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tgt_q      <= 1'b0;
      cnth_q     <= 8'd0;
      cnt_q      <= 16'd0;
      idx_q      <= 16'd0;
      bidx_q     <= 2'd0;
      asm_q      <= 32'd0;
      hold_q     <= 1'b1;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= 32'd0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnth_q     <= cnth_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      bidx_q     <= bidx_d;
      asm_q      <= asm_d;
      hold_q     <= hold_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign cpu_hold = hold_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader.
// Expected writes come from the session byte list.
module tb_prog_loader;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          tgt;
    int          addr;
    logic [31:0] data;
  } wr_t;

  int checks = 0;
  int failures = 0;
  wr_t got[$];
  logic [31:0] words[$];
  int cyc = 0;
  int done_cnt = 0;
  int rdy_in_write = 0;
  int both_we = 0;
  int done_hold_bad = 0;
  int last_we_cyc = -10;
  int last_done_cyc = -10;

  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (im_we && dm_we) both_we++;
    if (im_we) begin
      w.tgt = 1'b0; w.addr = int'(im_addr); w.data = im_wdata;
      got.push_back(w);
      last_we_cyc = cyc;
    end
    if (dm_we) begin
      w.tgt = 1'b1; w.addr = int'(dm_addr); w.data = dm_wdata;
      got.push_back(w);
      last_we_cyc = cyc;
    end
    if ((im_we || dm_we) && in_ready) rdy_in_write++;
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (cpu_hold) done_hold_bad++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    bit rdy;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 3);
      repeat (g) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data = b;
    guard = 0;
    rdy = 1'b0;
    while (!rdy && guard < 40) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    in_data = 8'($urandom);
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL send_byte: byte %02h not accepted in %0d cycles", b, guard);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gaps);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b1;
  endtask

  task automatic do_session(input logic [7:0] hdr, input logic [15:0] n,
                            input bit gaps);
    bit exp_err;
    int d0;
    int guard;
    int exp_n;
    exp_err = (hdr[6:0] != 7'd0) || (n > 16'(DEPTH));
    exp_n = exp_err ? 0 : int'(n);
    d0 = done_cnt;
    got.delete();
    rdy_in_write = 0;
    both_we = 0;
    done_hold_bad = 0;
    send_byte(hdr, gaps);
    @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL hold_after_hdr: got %b want 1", cpu_hold);
    end
    @(posedge clk); #1;
    if (hdr[6:0] == 7'd0) begin
      send_byte(n[15:8], gaps);
      send_byte(n[7:0], gaps);
      for (int i = 0; i < exp_n; i++) send_word(words[i], gaps);
    end
    guard = 0;
    while (done_cnt == d0 && !err && guard < 30) begin
      @(negedge clk); #1;
      guard++;
    end
    checks++;
    if (err !== exp_err) begin
      failures++;
      $display("FAIL err_flag: got %b want %b", err, exp_err);
    end
    checks++;
    if (done_cnt - d0 != (exp_err ? 0 : 1)) begin
      failures++;
      $display("FAIL done_count: got %0d want %0d", done_cnt - d0,
               exp_err ? 0 : 1);
    end
    checks++;
    if (got.size() != exp_n) begin
      failures++;
      $display("FAIL write_count: got %0d want %0d", got.size(), exp_n);
    end
    for (int i = 0; i < exp_n && i < got.size(); i++) begin
      checks++;
      if (got[i].tgt !== hdr[7] || got[i].addr != i ||
          got[i].data !== words[i]) begin
        failures++;
        $display("FAIL write_%0d: got t%0d a%0d %08h want t%0d a%0d %08h",
                 i, got[i].tgt, got[i].addr, got[i].data,
                 hdr[7], i, words[i]);
      end
    end
    checks++;
    if (rdy_in_write != 0 || both_we != 0) begin
      failures++;
      $display("FAIL write_cycle: ready_in_write %0d both_we %0d want 0 0",
               rdy_in_write, both_we);
    end
    if (!exp_err) begin
      checks++;
      if (cpu_hold !== 1'b0 || done_hold_bad != 0) begin
        failures++;
        $display("FAIL hold_release: got %b bad %0d want 0 0",
                 cpu_hold, done_hold_bad);
      end
      if (exp_n > 0) begin
        checks++;
        if (last_done_cyc != last_we_cyc + 1) begin
          failures++;
          $display("FAIL done_timing: done %0d we %0d want done=we+1",
                   last_done_cyc, last_we_cyc);
        end
        checks++;
        if (hdr[7] ? (dm_addr != ADDR_W'(exp_n - 1) ||
                      dm_wdata !== words[exp_n-1])
                   : (im_addr != ADDR_W'(exp_n - 1) ||
                      im_wdata !== words[exp_n-1])) begin
          failures++;
          $display("FAIL held_outputs: im %0d %08h dm %0d %08h want %0d %08h",
                   im_addr, im_wdata, dm_addr, dm_wdata,
                   exp_n - 1, words[exp_n-1]);
        end
      end
    end else begin
      checks++;
      if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL error_state: rdy %b hold %b busy %b want 0 1 0",
                 in_ready, cpu_hold, busy);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || im_we !== 1'b0 ||
        dm_we !== 1'b0 || im_addr !== '0 || dm_addr !== '0 ||
        im_wdata !== 32'd0 || dm_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_values: rdy %b hold %b busy %b done %b err %b",
               in_ready, cpu_hold, busy, done, err);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: rdy %b hold %b want 1 1",
               in_ready, cpu_hold);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_im_single;
    words.delete();
    words.push_back(32'h8C03_0000);
    do_session(8'h00, 16'h0001, 1'b0);
  endtask

  task automatic test_dm_two;
    words.delete();
    words.push_back(32'h0000_0009);
    words.push_back(32'h0000_0003);
    do_session(8'h80, 16'h0002, 1'b0);
  endtask

  task automatic test_zero_count;
    words.delete();
    do_session(8'h00, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back;
    fill_words(3);
    do_session(8'h80, 16'd3, 1'b0);
    fill_words(2);
    do_session(8'h00, 16'd2, 1'b0);
  endtask

  task automatic test_random;
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 8);
      fill_words(n);
      do_session({1'($urandom), 7'd0}, 16'(n), 1'($urandom));
    end
  endtask

  task automatic test_full_depth;
    fill_words(DEPTH);
    do_session(8'h80, 16'(DEPTH), 1'b0);
  endtask

  task automatic test_gapped;
    fill_words(4);
    do_session(8'h00, 16'd4, 1'b0);
    do_session(8'h00, 16'd4, 1'b1);
  endtask

  task automatic test_reset_mid;
    int d0;
    fill_words(4);
    got.delete();
    d0 = done_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1);
    send_word(words[0], 1'b1);
    send_word(words[1], 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    apply_reset(1);
    repeat (10) begin @(posedge clk); #1; end
    checks++;
    if (got.size() != 2 || cpu_hold !== 1'b1 || busy !== 1'b0 ||
        done_cnt != d0) begin
      failures++;
      $display("FAIL reset_mid: writes %0d hold %b busy %b dones %0d want 2 1 0 0",
               got.size(), cpu_hold, busy, done_cnt - d0);
    end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      checks++;
      if (got[i].tgt !== 1'b0 || got[i].addr != i ||
          got[i].data !== words[i]) begin
        failures++;
        $display("FAIL reset_mid_write_%0d: got a%0d %08h want a%0d %08h",
                 i, got[i].addr, got[i].data, i, words[i]);
      end
    end
  endtask

  task automatic check_recover(input string nm);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_sticky: err %b rdy %b want 1 0", nm, err, in_ready);
    end
    @(posedge clk); #1;
    apply_reset(1);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_recover: err %b hold %b rdy %b busy %b want 0 1 1 0",
               nm, err, cpu_hold, in_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_count_overflow;
    words.delete();
    do_session(8'h00, 16'h0081, 1'b0);
    check_recover("overflow");
  endtask

  task automatic test_bad_hdr;
    words.delete();
    do_session(8'h01, 16'h0001, 1'b0);
    check_recover("bad_hdr");
  endtask

  initial begin
    test_reset();
    test_im_single();
    test_dm_two();
    test_zero_count();
    test_back_to_back();
    test_random();
    test_full_depth();
    test_gapped();
    test_reset_mid();
    test_count_overflow();
    test_bad_hdr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
